// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;

  function automatic int iter_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int ITER_W = iter_w(MD_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  always_comb begin
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed Booth multiplier / restoring divider feeding HI/LO.
// Optional abort input is built when MULTDIV_ABORT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for mult_start / div_start
//   MULT  | one Booth step per cycle, WIDTH cycles
//   DIV   | one restoring step per cycle, WIDTH cycles
//   FIX   | apply quotient / remainder signs
//   DONE  | one-cycle done pulse, results on hi_out/lo_out
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MULTDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div0
);

  localparam int CNT_W = iter_w(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi_out;
  logic [WIDTH-1:0] r_lo_out;

  logic             w_abort;
  logic             w_cnt_tc;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH-1:0] w_booth_hi;
  logic [WIDTH-1:0] w_booth_lo;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

`ifdef MULTDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_cnt_tc = (r_cnt == CNT_W'(1));
  assign w_a_mag  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign w_b_mag  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  // Hi is extended by one bit so that adding/subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    case ({r_lo[0], r_q})
      2'b01:   w_booth_sum = {r_hi[WIDTH-1], r_hi} + {r_b[WIDTH-1], r_b};
      2'b10:   w_booth_sum = {r_hi[WIDTH-1], r_hi} - {r_b[WIDTH-1], r_b};
      default: w_booth_sum = {r_hi[WIDTH-1], r_hi};
    endcase
  end

  assign w_booth_hi = w_booth_sum[WIDTH:1];
  assign w_booth_lo = {w_booth_sum[0], r_lo[WIDTH-1:1]};

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (r_hi),
    .i_quo     (r_lo),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_quo     (w_div_quo)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_abort) begin
          if (mult_start)     w_state_nxt = MULT;
          else if (div_start) w_state_nxt = (b_in == '0) ? DONE : DIV;
        end
      end
      MULT: begin
        if (w_abort)       w_state_nxt = IDLE;
        else if (w_cnt_tc) w_state_nxt = DONE;
      end
      DIV: begin
        if (w_abort)       w_state_nxt = IDLE;
        else if (w_cnt_tc) w_state_nxt = FIX;
      end
      FIX:     w_state_nxt = w_abort ? IDLE : DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_q      <= 1'b0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          r_div0 <= 1'b0;
          if (!w_abort && mult_start) begin
            r_hi  <= '0;
            r_lo  <= b_in;
            r_q   <= 1'b0;
            r_b   <= a_in;
            r_cnt <= CNT_W'(WIDTH);
          end else if (!w_abort && div_start) begin
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            r_cnt   <= CNT_W'(WIDTH);
            r_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_r <= a_in[WIDTH-1];
            r_div0  <= (b_in == '0);
          end
        end
        MULT: begin
          if (!w_abort) begin
            r_hi  <= w_booth_hi;
            r_lo  <= w_booth_lo;
            r_q   <= r_lo[0];
            r_cnt <= r_cnt - 1'b1;
            if (w_cnt_tc) begin
              r_hi_out <= w_booth_hi;
              r_lo_out <= w_booth_lo;
            end
          end
        end
        DIV: begin
          if (!w_abort) begin
            r_hi  <= w_div_rem;
            r_lo  <= w_div_quo;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (!w_abort) begin
            r_hi_out <= r_neg_r ? (~r_hi + 1'b1) : r_hi;
            r_lo_out <= r_neg_q ? (~r_lo + 1'b1) : r_lo;
          end
        end
        DONE:    r_div0 <= 1'b0;
        default: r_div0 <= 1'b0;
      endcase
    end
  end

  assign done   = (r_state == DONE);
  assign busy   = (r_state == MULT) || (r_state == DIV) || (r_state == FIX);
  assign div0   = done && r_div0;
  assign hi_out = r_hi_out;
  assign lo_out = r_lo_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div0;
  logic [31:0] hi_out, lo_out;
`ifdef MULTDIV_ABORT_EN
  logic        abort = 1'b0;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULTDIV_ABORT_EN
    .abort      (abort),
`endif
    .mult_start (mult_start),
    .div_start  (div_start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div0       (div0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The accepting edge counts as edge 1; done is sampled after edge `lat`.
  task automatic do_op(input bit mul, input bit dv, input logic [31:0] a,
                       input logic [31:0] b, input int inj, input bit poke);
    longint p, q, r;
    logic [31:0] e_hi, e_lo;
    bit e_d0;
    int lat, cyc;
    e_hi = m_hi; e_lo = m_lo; e_d0 = 1'b0;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e_hi = p[63:32]; e_lo = p[31:0]; lat = 33;
    end else if (b == 32'd0) begin
      e_d0 = 1'b1; lat = 1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      e_hi = r[31:0]; e_lo = q[31:0]; lat = 34;
    end
    @(negedge clk);
    a_in = a; b_in = b; mult_start = mul; div_start = dv;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    a_in = $urandom; b_in = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      check("busy_running", {63'd0, busy}, 64'd1);
      div_start = (cyc == inj);
      @(negedge clk);
      cyc++;
    end
    div_start = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    check("busy_in_done", {63'd0, busy}, 64'd0);
    check("hi_out", {32'd0, hi_out}, {32'd0, e_hi});
    check("lo_out", {32'd0, lo_out}, {32'd0, e_lo});
    check("div0", {63'd0, div0}, {63'd0, e_d0});
    if (poke) mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    check("done_pulse_1cyc", {63'd0, done}, 64'd0);
    check("div0_after_done", {63'd0, div0}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
    m_hi = e_hi; m_lo = e_lo;
  endtask

  task automatic expect_no_done(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div0", {63'd0, div0}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(1'b0, 1'b1, 32'h0000_00BA, 32'h10, 0, 1'b0);
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0);
    do_op(1'b1, 1'b1, 32'd6, 32'd4, 10, 1'b0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi_out}, 64'd0);
    check("midrst_lo", {32'd0, lo_out}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    expect_no_done("no_done_after_reset", 40);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

`ifdef MULTDIV_ABORT_EN
    do_op(1'b1, 1'b0, 32'd9, 32'd9, 0, 1'b0);
    @(negedge clk);
    a_in = 32'd123; b_in = 32'd456; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_drop", {63'd0, busy}, 64'd0);
    expect_no_done("abort_no_done", 40);
    check("abort_hi_kept", {32'd0, hi_out}, {32'd0, m_hi});
    check("abort_lo_kept", {32'd0, lo_out}, {32'd0, m_lo});
    abort = 1'b1; div_start = 1'b1; a_in = 32'd8; b_in = 32'd2;
    @(negedge clk);
    abort = 1'b0; div_start = 1'b0;
    check("abort_beats_start", {63'd0, busy}, 64'd0);
    expect_no_done("abort_start_dropped", 40);
    do_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd7, 0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      bit rm;
      ra = pick();
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      rm = $urandom_range(0, 1) == 1;
      do_op(rm, ~rm | ($urandom_range(0, 3) == 0), ra, rb, 0, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
